// File: rtl/serial_shifter.sv
// ---------------------------------------------------------------------------
// serial_shifter
//   Iterative 32-bit shift unit. It applies one single-bit shift per clock
//   under a start/busy/done handshake. Supported operations are sll, srl, sra
//   and rol, each by a 5-bit amount. It is the area-light alternative to the
//   single-cycle barrel shifters and suits shift instructions that can
//   tolerate a variable latency.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request; only sampled while idle
//   op       00 sll, 01 srl, 10 sra, 11 rol; captured on the accepted start
//   a        32-bit operand; captured on the accepted start
//   shamt    shift amount 0..31; captured on the accepted start
//   busy     high whenever the unit is not idle
//   done     one-cycle completion pulse
//   result   shifted value; valid with done, held until the next accepted start
// ---------------------------------------------------------------------------
module serial_shifter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned OW = 2;

    localparam logic [OW-1:0] OP_SLL = 2'b00;
    localparam logic [OW-1:0] OP_SRL = 2'b01;
    localparam logic [OW-1:0] OP_SRA = 2'b10;
    localparam logic [OW-1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] data;
    logic [DW-1:0] data_nxt;
    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_nxt;
    logic [OW-1:0] op_q;
    logic [OW-1:0] op_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          accept;

    // Single-bit step of the captured operation.
    function automatic logic [DW-1:0] shift_one(input logic [DW-1:0] d,
                                                input logic [OW-1:0] o);
        logic [DW-1:0] r;
        r = d;
        case (o)
            OP_SLL:  r = {d[DW-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[DW-1:1]};
            OP_SRA:  r = {d[DW-1], d[DW-1:1]};
            OP_ROL:  r = {d[DW-2:0], d[DW-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // A request is only honoured while idle; anything else is dropped.
    assign accept = (state == ST_IDLE) && start;

    // State register plus registered Moore outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // A zero amount skips the shift phase entirely.
                    state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cnt == 1 means this edge performs the final shift.
                if (cnt == SW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so busy and
    // done line up with the state they describe without any input-to-output path.
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            ST_SHIFT: begin
                busy_nxt = 1'b1;
            end
            ST_DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
            end
        endcase
    end

    // Datapath next values: load on an accepted start, one step per SHIFT cycle.
    always_comb begin
        data_nxt = data;
        cnt_nxt  = cnt;
        op_nxt   = op_q;
        if (accept) begin
            data_nxt = a;
            cnt_nxt  = shamt;
            op_nxt   = op;
        end else if (state == ST_SHIFT) begin
            data_nxt = shift_one(data, op_q);
            cnt_nxt  = cnt - SW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            cnt  <= '0;
            op_q <= OP_SLL;
        end else begin
            data <= data_nxt;
            cnt  <= cnt_nxt;
            op_q <= op_nxt;
        end
    end

    // The working register is the result; it holds once the unit returns to idle.
    assign result = data;

endmodule

// File: tb/tb_serial_shifter.sv
// ---------------------------------------------------------------------------
// tb_serial_shifter
//   Directed and randomized checks of serial_shifter against a behavioural
//   model built from the shift operators. Inputs change 1 time unit after a
//   rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_serial_shifter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_shifter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Reference: the full shift computed in one step.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input int s);
        logic [31:0] r;
        case (o)
            2'b00:   r = x << s;
            2'b01:   r = x >> s;
            2'b10:   r = 32'($signed(x) >>> s);
            default: r = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request. This task assumes it is called at a sample point in
    // an IDLE cycle. With noise set, start is held high with random operands
    // for every busy cycle, including the DONE cycle, and those requests must
    // all be dropped. The task returns at the sample point of the following
    // IDLE cycle, which is the earliest point at which a new start is legal.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input int s,
                       input bit noise, input string tag);
        logic [31:0] exp;
        int          cyc;
        int          bcyc;
        exp  = model(o, x, s);
        cyc  = 0;
        bcyc = 0;
        op    = o;
        a     = x;
        shamt = 5'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = noise;
        if (noise) begin
            a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
        end
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            cyc++;
            @(posedge clk);
            #1;
            if (noise) begin
                a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
            end
        end
        if (busy) bcyc++;
        chk({tag, " done"}, 32'(done), 32'd1);
        // A zero amount goes straight to DONE, so the edge count equals shamt.
        chk({tag, " latency"}, 32'(cyc), 32'(s));
        chk({tag, " busy_cycles"}, 32'(bcyc), 32'(s + 1));
        chk({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_done"}, 32'(done), 32'd0);
        chk({tag, " hold"}, result, exp);
    endtask

    initial begin
        logic [31:0] sweep_a [2];
        sweep_a[0] = 32'h5555_5555;
        sweep_a[1] = 32'hAAAA_AAAA;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        shamt   = '0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst busy", 32'(busy), 32'd0);

        // Directed cases.
        run(2'b00, 32'h5555_5555, 1, 1'b0, "sll1");
        chk("sll1 value", result, 32'hAAAA_AAAA);
        run(2'b01, 32'hAAAA_AAAA, 31, 1'b0, "srl31");
        chk("srl31 value", result, 32'h0000_0001);
        run(2'b10, 32'hAAAA_AAAA, 31, 1'b0, "sra31neg");
        chk("sra31neg value", result, 32'hFFFF_FFFF);
        run(2'b10, 32'h5555_5555, 31, 1'b0, "sra31pos");
        chk("sra31pos value", result, 32'h0000_0000);
        for (int o = 0; o < 4; o++) begin
            run(2'(o), 32'h1234_5678, 0, 1'b0, "zero");
            chk("zero value", result, 32'h1234_5678);
        end
        run(2'b11, 32'h8000_0001, 4, 1'b0, "rol4");
        chk("rol4 value", result, 32'h0000_0018);

        // Requests while busy, including during DONE, must be dropped.
        run(2'b00, 32'h0000_00F0, 5, 1'b1, "ignore_sll5");
        chk("ignore_sll5 value", result, 32'h0000_1E00);
        run(2'b11, 32'hC000_0003, 0, 1'b1, "ignore_zero");
        run(2'b10, 32'h8765_4321, 9, 1'b1, "ignore_sra9");

        // Reset in the middle of a shift aborts it without a done pulse.
        op = 2'b01; a = 32'hF0F0_F0F0; shamt = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("mid busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release busy", 32'(busy), 32'd0);
        run(2'b00, 32'h0000_0001, 3, 1'b0, "after_rst");
        chk("after_rst value", result, 32'h0000_0008);

        // Sweep both alternating patterns over every op and amount.
        for (int i = 0; i < 2; i++) begin
            for (int o = 0; o < 4; o++) begin
                for (int s = 0; s < 32; s++) begin
                    run(2'(o), sweep_a[i], s, 1'b0, $sformatf("sweep a=%h op=%0d s=%0d", sweep_a[i], o, s));
                end
            end
        end

        // Random operands, with busy-time request noise on every other run.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [1:0]  ro;
            int          rs;
            ra = $urandom;
            ro = 2'($urandom);
            rs = int'($urandom_range(31, 0));
            run(ro, ra, rs, k[0], $sformatf("rand%0d op=%0d s=%0d", k, ro, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
